// File: rtl/e203_exu_dsp_wbck_pkg.sv
// DSP write-back shared definitions.
// State encoding and width defaults for the DSP write-back path.
package e203_exu_dsp_wbck_pkg;

    localparam int E203_XLEN    = 32;
    localparam int E203_RFIDX_W = 5;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_LO   = 2'd1,
        WB_HI   = 2'd2
    } dsp_wbck_state_e;

endpackage

// File: rtl/e203_dsp_wbck_capture.sv
// DSP write-back capture bank.
// Holds one accepted DSP result until both halves are written back.
module e203_dsp_wbck_capture
    import e203_exu_dsp_wbck_pkg::*;
#(
    parameter int XLEN    = E203_XLEN,
    parameter int RFIDX_W = E203_RFIDX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [XLEN-1:0]    in_wdat,
    input  logic [XLEN-1:0]    in_wdat_1,
    input  logic [RFIDX_W-1:0] in_rdidx,
    input  logic               in_64b,
    input  logic               in_err,
    input  logic               in_ov,
    output logic [XLEN-1:0]    q_wdat,
    output logic [XLEN-1:0]    q_wdat_1,
    output logic [RFIDX_W-1:0] q_rdidx,
    output logic               q_64b,
    output logic               q_err,
    output logic               q_ov
);

    // Data and index are only meaningful while a write is pending.
    always_ff @(posedge clk) begin
        if (load) begin
            q_wdat   <= in_wdat;
            q_wdat_1 <= in_wdat_1;
            q_rdidx  <= in_rdidx;
        end
    end

    // Control flags are cleared so a reset never leaks a stale tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_64b <= 1'b0;
            q_err <= 1'b0;
            q_ov  <= 1'b0;
        end else if (load) begin
            q_64b <= in_64b;
            q_err <= in_err;
            q_ov  <= in_ov;
        end
    end

endmodule

// File: rtl/e203_exu_dsp_wbck.sv
// DSP result write-back sequencer.
// Splits 64-bit results into rd / rd+1 writes toward exu_wbck.
module e203_exu_dsp_wbck
    import e203_exu_dsp_wbck_pkg::*;
#(
    parameter int XLEN    = E203_XLEN,
    parameter int RFIDX_W = E203_RFIDX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dsp_i_valid,
    output logic               dsp_i_ready,
    input  logic [XLEN-1:0]    dsp_i_wdat,
    input  logic [XLEN-1:0]    dsp_i_wdat_1,
    input  logic               dsp_i_64b,
    input  logic [RFIDX_W-1:0] dsp_i_rdidx,
    input  logic               dsp_i_err,
    input  logic               dsp_i_ov,
    output logic               wbck_o_valid,
    input  logic               wbck_o_ready,
    output logic [XLEN-1:0]    wbck_o_wdat,
    output logic [RFIDX_W-1:0] wbck_o_rdidx,
    output logic               wbck_o_err,
    output logic               ov_set_o,
    output logic               busy_o
);

    dsp_wbck_state_e state_q;
    dsp_wbck_state_e state_d;

    logic               accept;
    logic [XLEN-1:0]    cap_wdat;
    logic [XLEN-1:0]    cap_wdat_1;
    logic [RFIDX_W-1:0] cap_rdidx;
    logic               cap_64b;
    logic               cap_err;
    logic               cap_ov;
    logic               odd_pair;
    logic               pair_go;

    assign dsp_i_ready = (state_q == WB_IDLE);
    assign busy_o      = (state_q != WB_IDLE);
    assign accept      = dsp_i_valid & dsp_i_ready;

    // A pair write needs an even rd; odd rd is flagged as an error.
    assign odd_pair = cap_64b & cap_rdidx[0];
    assign pair_go  = cap_64b & ~cap_err & ~cap_rdidx[0];

    e203_dsp_wbck_capture #(
        .XLEN    (XLEN),
        .RFIDX_W (RFIDX_W)
    ) u_capture (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .in_wdat   (dsp_i_wdat),
        .in_wdat_1 (dsp_i_wdat_1),
        .in_rdidx  (dsp_i_rdidx),
        .in_64b    (dsp_i_64b),
        .in_err    (dsp_i_err),
        .in_ov     (dsp_i_ov),
        .q_wdat    (cap_wdat),
        .q_wdat_1  (cap_wdat_1),
        .q_rdidx   (cap_rdidx),
        .q_64b     (cap_64b),
        .q_err     (cap_err),
        .q_ov      (cap_ov)
    );

    // State register; reset drops any pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and write-back outputs.
    always_comb begin
        state_d      = state_q;
        wbck_o_valid = 1'b0;
        wbck_o_wdat  = cap_wdat;
        wbck_o_rdidx = cap_rdidx;
        wbck_o_err   = 1'b0;
        ov_set_o     = 1'b0;
        unique case (state_q)
            WB_IDLE: begin
                if (dsp_i_valid) begin
                    state_d = WB_LO;
                end
            end
            WB_LO: begin
                wbck_o_valid = 1'b1;
                wbck_o_err   = cap_err | odd_pair;
                ov_set_o     = cap_ov & wbck_o_ready;
                if (wbck_o_ready) begin
                    state_d = pair_go ? WB_HI : WB_IDLE;
                end
            end
            WB_HI: begin
                wbck_o_valid = 1'b1;
                wbck_o_wdat  = cap_wdat_1;
                wbck_o_rdidx = cap_rdidx + RFIDX_W'(1);
                if (wbck_o_ready) begin
                    state_d = WB_IDLE;
                end
            end
            default: begin
                state_d = WB_IDLE;
            end
        endcase
    end

endmodule
